// File: rtl/hull_fifo_counter64.sv
`default_nettype none
// ============================================================================
// hull_fifo_counter64 : FWFT synchronous FIFO plus free-running 64-bit counter.
// Macro HULL_FIFO_ERR_EN adds sticky overflow/underflow outputs.   Rev 1.0
// ============================================================================
module hull_fifo_counter64 #(
  parameter int TYPE      = 0,
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  input  logic             rdreq,
  input  logic             increment,
  output logic [63:0]      count
`ifdef HULL_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int                 DEPTH   = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] C_DEPTH = (LOG_DEPTH+1)'(DEPTH);

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   occ_q, occ_d;
  logic [63:0]          count_q, count_d;
  logic                 wr_en, rd_en;
  logic [WIDTH-1:0]     head;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == C_DEPTH);
  assign q     = empty ? '0 : head;
  assign count = count_q;

  always_comb begin
    wr_en    = wrreq & ~full;
    rd_en    = rdreq & ~empty;
    wr_ptr_d = wr_en ? wr_ptr_q + LOG_DEPTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + LOG_DEPTH'(1) : rd_ptr_q;
    occ_d    = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + (LOG_DEPTH+1)'(1);
      2'b01:   occ_d = occ_q - (LOG_DEPTH+1)'(1);
      default: occ_d = occ_q;
    endcase
    count_d  = count_q + {63'd0, increment};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  generate
    if (TYPE == 1) begin : g_ram
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] mem_rd_q;
      logic [WIDTH-1:0] byp_data_q;
      logic             byp_q;

      // Synchronous read of the next head; a same-edge write to that slot is forwarded.
      always_ff @(posedge clock) begin
        if (wr_en) begin
          mem[wr_ptr_q] <= data;
        end
        mem_rd_q   <= mem[rd_ptr_d];
        byp_data_q <= data;
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          byp_q <= 1'b0;
        end else begin
          byp_q <= wr_en && (wr_ptr_q == rd_ptr_d);
        end
      end

      assign head = byp_q ? byp_data_q : mem_rd_q;
    end else begin : g_ff
      logic [WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clock) begin
        if (wr_en) begin
          mem[wr_ptr_q] <= data;
        end
      end

      assign head = mem[rd_ptr_q];
    end
  endgenerate

`ifdef HULL_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wrreq && full) begin
        overflow_q <= 1'b1;
      end
      if (rdreq && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hull_fifo_counter64.sv
`default_nettype none
// Bench for hull_fifo_counter64: both storage types driven in lockstep and
// checked against a queue-based reference model through a scoreboard.
module tb_hull_fifo_counter64;
  localparam int WIDTH     = 64;
  localparam int LOG_DEPTH = 3;
  localparam int DEPTH     = 1 << LOG_DEPTH;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic             wrreq     = 1'b0;
  logic             rdreq     = 1'b0;
  logic             increment = 1'b0;
  logic [WIDTH-1:0] data      = '0;
  logic             full0, empty0, full1, empty1;
  logic [WIDTH-1:0] q0, q1;
  logic [63:0]      count0, count1;
`ifdef HULL_FIFO_ERR_EN
  logic             ovf0, unf0, ovf1, unf1;
`endif

  always #5 clock = ~clock;

  hull_fifo_counter64 #(.TYPE(0), .WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH)) dut0 (
    .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .full(full0),
    .q(q0), .empty(empty0), .rdreq(rdreq), .increment(increment), .count(count0)
`ifdef HULL_FIFO_ERR_EN
    , .overflow(ovf0), .underflow(unf0)
`endif
  );

  hull_fifo_counter64 #(.TYPE(1), .WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH)) dut1 (
    .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .full(full1),
    .q(q1), .empty(empty1), .rdreq(rdreq), .increment(increment), .count(count1)
`ifdef HULL_FIFO_ERR_EN
    , .overflow(ovf1), .underflow(unf1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted words plus occupancy/counter/sticky state.
  logic [WIDTH-1:0] exp_q[$];
  int               model_cnt = 0;
  int               pre_cnt   = 0;
  bit               rd_ok     = 1'b0;
  logic [63:0]      exp_count = '0;
  logic [63:0]      pre_count = '0;
  bit               ovf_m = 1'b0, unf_m = 1'b0, pre_ovf = 1'b0, pre_unf = 1'b0;
  bit               in_reset  = 1'b1;
  logic [63:0]      force_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's requests and update the model for the coming edge.
  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit inc);
    @(posedge clock);
    #2;
    wrreq = wr; data = d; rdreq = rd; increment = inc;
    pre_cnt   = model_cnt;
    pre_count = exp_count;
    pre_ovf   = ovf_m;
    pre_unf   = unf_m;
    rd_ok     = rd && (pre_cnt > 0);
    if (wr && pre_cnt < DEPTH) begin
      exp_q.push_back(d);
      model_cnt++;
    end
    if (rd_ok) model_cnt--;
    if (wr && pre_cnt == DEPTH) ovf_m = 1'b1;
    if (rd && pre_cnt == 0) unf_m = 1'b1;
    if (inc) exp_count = exp_count + 64'd1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_cnt = 0; pre_cnt = 0; rd_ok = 1'b0;
    exp_count = '0; pre_count = '0;
    ovf_m = 1'b0; unf_m = 1'b0; pre_ovf = 1'b0; pre_unf = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty0"}, empty0, 1'b1);
    chk({tag, "_full0"},  full0,  1'b0);
    chk({tag, "_q0"},     q0,     '0);
    chk({tag, "_count0"}, count0, '0);
    chk({tag, "_empty1"}, empty1, 1'b1);
    chk({tag, "_full1"},  full1,  1'b0);
    chk({tag, "_q1"},     q1,     '0);
    chk({tag, "_count1"}, count1, '0);
  endtask

  // Reset lands between edges so its asynchronous effect is observable at once.
  task automatic async_reset();
    @(posedge clock);
    #3;
    wrreq = 1'b0; rdreq = 1'b0; increment = 1'b0;
    in_reset = 1'b1;
    reset_n  = 1'b0;
    #1;
    check_reset_state("async_rst");
    clear_model();
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares the state that precedes each edge; pops the head when a read is due.
  always @(negedge clock) begin : mon
    logic [WIDTH-1:0] e;
    if (!in_reset) begin
      chk("empty0", empty0, pre_cnt == 0);
      chk("empty1", empty1, pre_cnt == 0);
      chk("full0",  full0,  pre_cnt == DEPTH);
      chk("full1",  full1,  pre_cnt == DEPTH);
      chk("count0", count0, pre_count);
      chk("count1", count1, pre_count);
`ifdef HULL_FIFO_ERR_EN
      chk("overflow0",  ovf0, pre_ovf);
      chk("overflow1",  ovf1, pre_ovf);
      chk("underflow0", unf0, pre_unf);
      chk("underflow1", unf1, pre_unf);
`endif
      if (pre_cnt == 0) begin
        chk("q0_empty", q0, '0);
        chk("q1_empty", q1, '0);
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got no expected entry required %0d entries", pre_cnt);
      end else begin
        e = exp_q[0];
        chk("q0_head", q0, e);
        chk("q1_head", q1, e);
        if (rd_ok) exp_q.pop_front();
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    #12;
    check_reset_state("init_rst");
    @(posedge clock);
    #2;
    reset_n  = 1'b1;
    in_reset = 1'b0;

    // Counter: five increments.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("count_five", count0, 64'd5);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(64'h10 + i), 1'b0, 1'b0);
    step(1'b1, WIDTH'(64'hFF), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // FWFT: head visible the cycle after the write, before any read.
    step(1'b1, WIDTH'(64'hABCD), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous read/write at occupancy 1, full and empty.
    step(1'b1, WIDTH'(64'h1), 1'b0, 1'b0);
    step(1'b1, WIDTH'(64'h2), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(64'h100 + i), 1'b0, 1'b0);
    step(1'b1, WIDTH'(64'hEE), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, WIDTH'(64'h55), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap with interleaved pairs.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(64'h300 + i), 1'b0, 1'b1);
    async_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), {$urandom, $urandom},
           ($urandom_range(0, 99) < 45), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Counter wrap from 2^64-2.
    step(1'b0, '0, 1'b0, 1'b0);
    #1;
    force_val = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut0.count_q = force_val;
    force dut1.count_q = force_val;
    #1;
    release dut0.count_q;
    release dut1.count_q;
    exp_count = force_val;
    pre_count = force_val;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("count_wrap0", count0, '0);
    chk("count_wrap1", count1, '0);

    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
